// File: rtl/shift_req_fifo_if.sv
// Request/result bundle between the shift-request FIFO stage, its producer,
// the combinational shifter and the result consumer.
// Latency: none (wires only). Backpressure: carried by in_ready / out_ready.
interface shift_req_fifo_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [WIDTH-1:0] sh_i;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH-1:0] sh_o;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SHW-1:0]   out_amt;
  logic [LW-1:0]    level;

  modport master (
    output in_valid, in_data, in_amt, sh_o, out_ready,
    input  in_ready, sh_i, sh_s, out_valid, out_data, out_amt, level
  );

  modport slave (
    input  in_valid, in_data, in_amt, sh_o, out_ready,
    output in_ready, sh_i, sh_s, out_valid, out_data, out_amt, level
  );
endinterface

// File: rtl/shift_req_fifo.sv
// Buffers shift requests in a DEPTH-entry FIFO and registers the shifter result.
// Latency: push at edge N gives out_valid after edge N+1; 1 result/cycle streaming.
// Backpressure: in_ready from occupancy only; result held stable while out_ready=0.
module shift_req_fifo #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_req_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
  } req_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SHW-1:0]   out_amt_q;
  logic             push;
  logic             load;

  assign head         = mem[rd_ptr];
  assign bus.sh_i     = head.data;
  assign bus.sh_s     = head.amt;
  assign bus.in_ready = (level_q != LW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  // An entry pushed into an empty FIFO is not visible to load until next edge.
  assign load         = (level_q != '0) && (!out_valid_q || bus.out_ready);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_amt   = out_amt_q;
  assign bus.level     = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= req_t'{data: bus.in_data, amt: bus.in_amt};
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_amt_q   <= '0;
    end else if (load) begin
      rd_ptr      <= rd_ptr + 1'b1;
      out_valid_q <= 1'b1;
      out_data_q  <= bus.sh_o;
      out_amt_q   <= head.amt;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      case ({push, load})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_req_fifo.sv
// Bench for shift_req_fifo: directed scenarios followed by random traffic,
// all checked against a queue-based model of the request/result flow.
module tb_shift_req_fifo;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   a;
  } mreq_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mreq_t            mq[$];
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic [SHW-1:0]   m_oa;

  shift_req_fifo_if #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) bus ();

  shift_req_fifo #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural shifter placed between the head outputs and sh_o.
  assign bus.sh_o = bus.sh_i << bus.sh_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_od = '0;
    m_oa = '0;
  endtask

  task automatic compare_model();
    check("level", 32'(bus.level), 32'(mq.size()));
    check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", 32'(bus.out_data), 32'(m_od));
      check("out_amt", 32'(bus.out_amt), 32'(m_oa));
    end
    if (mq.size() != 0) begin
      check("sh_i", 32'(bus.sh_i), 32'(mq[0].d));
      check("sh_s", 32'(bus.sh_s), 32'(mq[0].a));
    end
  endtask

  // One clock edge: decide push/pop from pre-edge state, then compare.
  task automatic tick();
    bit    do_push;
    bit    do_load;
    bit    rdy;
    mreq_t h;
    mreq_t n;
    rdy     = bus.out_ready;
    do_push = bus.in_valid && (mq.size() < DEPTH);
    do_load = (mq.size() != 0) && (!m_ov || rdy);
    n.d     = bus.in_data;
    n.a     = bus.in_amt;
    @(posedge clk);
    #1;
    if (do_load) begin
      h    = mq.pop_front();
      m_od = h.d << h.a;
      m_oa = h.a;
      m_ov = 1'b1;
    end else if (m_ov && rdy) begin
      m_ov = 1'b0;
    end
    if (do_push) mq.push_back(n);
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
  endtask

  initial begin
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] exp_d[4];
    logic [SHW-1:0]   exp_a[4];
    int               first_v;
    int               last_v;
    int               max_lvl;
    int               n;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    model_reset();

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_sh_i", 32'(bus.sh_i), 32'd0);
    check("rst_sh_s", 32'(bus.sh_s), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_amt", 32'(bus.out_amt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset with requests queued
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hA5A0 + 16'(i), 4'(i + 1));
      tick();
    end
    drive(1'b0, '0, '0);
    check("pre_rst_level", 32'(bus.level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_level", 32'(bus.level), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_sh_i", 32'(bus.sh_i), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: two-edge latency
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 4'd1);
    tick();
    check("single_edge1_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, '0, '0);
    tick();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data", 32'(bus.out_data), 32'hFFFE);
    check("single_amt", 32'(bus.out_amt), 32'd1);
    check("single_level", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // Fill behind a held result, then attempt a fifth push
    exp_a[0] = 4'd0; exp_a[1] = 4'd2; exp_a[2] = 4'd4; exp_a[3] = 4'd8;
    exp_d[0] = 16'hFFFF; exp_d[1] = 16'hFFFC; exp_d[2] = 16'hFFF0; exp_d[3] = 16'hFF00;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hFFFF, exp_a[i]);
      tick();
    end
    check("fill_level", 32'(bus.level), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h1234, 4'd3);
    tick();
    check("fill_5th_level", 32'(bus.level), 32'd4);
    drive(1'b0, '0, '0);

    // Stall: result and occupancy frozen
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", 32'(bus.out_data), 32'hFFFE);
      check("stall_amt", 32'(bus.out_amt), 32'd1);
      check("stall_level", 32'(bus.level), 32'd4);
    end

    // Release: queued results drain in order
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'd1);
      check("drain_data", 32'(bus.out_data), 32'(exp_d[i]));
      check("drain_amt", 32'(bus.out_amt), 32'(exp_a[i]));
    end
    tick();
    check("drain_empty_valid", 32'(bus.out_valid), 32'd0);

    // Streaming: one result per cycle, pointers wrap
    first_v = -1;
    last_v  = -1;
    max_lvl = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) drive(1'b1, 16'h0001, 4'(c));
      else        drive(1'b0, '0, '0);
      tick();
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      if (bus.out_valid) begin
        got.push_back(bus.out_data);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    check("stream_count", 32'(got.size()), 32'd16);
    check("stream_contiguous", 32'(last_v - first_v + 1), 32'd16);
    check("stream_max_level", 32'(max_lvl <= 2), 32'd1);
    n = (got.size() < 16) ? got.size() : 16;
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] e;
      e = 16'h0001 << i;
      check("stream_data", 32'(got[i]), 32'(e));
    end

    // Simultaneous: full FIFO, pop then push
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00F0, 4'd2);
    for (int i = 0; i < 8 && bus.level != 3'd4; i++) tick();
    check("simul_full", 32'(bus.level), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    check("simul_pop", 32'(bus.level), 32'd3);
    bus.out_ready = 1'b0;
    tick();
    check("simul_push", 32'(bus.level), 32'd4);
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (6) tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check("final_level", 32'(bus.level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
